// File: rtl/spi_cmd_memory_ctrl.sv
// SPI command decoder: assembles {addr_msb, addr_lsb, instr, data} frames and applies them
// to a byte-wide configuration register file, with burst writes and inter-byte timeout.
module spi_cmd_memory_ctrl #(
    parameter int MEM_BYTES   = 164,
    parameter int ADDR_W      = 8,
    parameter int CLKDIV_ADDR = 6,
    parameter int DEBUG_ADDR  = 163,
    parameter int TIMEOUT     = 1023
) (
    input  logic                   system_clock,
    input  logic                   rst_n,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_in,
    output logic [MEM_BYTES*8-1:0] all_data_out,
    output logic [7:0]             tx_byte,
    output logic                   tx_load,
    output logic                   spi_instruction_done,
    output logic                   clk_div_load,
    output logic                   debug_config_load,
    output logic                   param_update,
    output logic                   cmd_error,
    output logic                   frame_abort,
    output logic                   busy
);

    localparam int GW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [7:0] I_READ  = 8'h00;
    localparam logic [7:0] I_WRITE = 8'h01;
    localparam logic [7:0] I_CLKDV = 8'h05;
    localparam logic [7:0] I_PARAM = 8'h07;
    localparam logic [7:0] I_DEBUG = 8'h09;
    localparam logic [7:0] I_BURST = 8'h0B;

    typedef enum logic [2:0] {S_MSB, S_LSB, S_INSTR, S_DATA, S_BURST} state_t;

    state_t                        state_q, state_d;
    logic [7:0]                    msb_q, msb_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic [7:0]                    instr_q, instr_d;
    logic [ADDR_W:0]               ptr_q, ptr_d;
    logic [GW-1:0]                 gap_q, gap_d;
    logic [7:0]                    tx_d;
    logic                          tx_load_d, done_d, clk_d, dbg_d, param_d, err_d, abort_d;
    logic [MEM_BYTES-1:0][7:0]     mem;
    logic                          wr_en;
    logic [ADDR_W:0]               wr_addr;
    logic [7:0]                    rd_byte;
    logic                          addr_ok, ptr_ok;

    assign all_data_out = mem;
    assign busy         = (state_q != S_MSB);
    assign addr_ok      = 32'(addr_q) < MEM_BYTES;
    assign ptr_ok       = 32'(ptr_q) < MEM_BYTES;

    always_comb begin
        rd_byte = '0;
        for (int k = 0; k < MEM_BYTES; k++)
            if (32'(addr_q) == k) rd_byte = mem[k];
    end

    always_comb begin
        state_d   = state_q;
        msb_d     = msb_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        ptr_d     = ptr_q;
        gap_d     = (state_q == S_MSB) ? '0 : gap_q + 1'b1;
        tx_d      = tx_byte;
        tx_load_d = 1'b0;
        done_d    = 1'b0;
        clk_d     = 1'b0;
        dbg_d     = 1'b0;
        param_d   = 1'b0;
        err_d     = 1'b0;
        abort_d   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = {1'b0, addr_q};

        if (byte_valid) begin
            // A byte arriving on the expiry cycle still belongs to the current frame.
            gap_d = '0;
            unique case (state_q)
                S_MSB: begin
                    msb_d   = byte_in;
                    state_d = S_LSB;
                end
                S_LSB: begin
                    addr_d  = ADDR_W'({msb_q, byte_in});
                    state_d = S_INSTR;
                end
                S_INSTR: begin
                    instr_d = byte_in;
                    state_d = S_DATA;
                    if (byte_in == I_READ) begin
                        tx_load_d = 1'b1;
                        tx_d      = addr_ok ? rd_byte : 8'h00;
                    end
                end
                S_DATA: begin
                    done_d  = 1'b1;
                    state_d = S_MSB;
                    unique case (instr_q)
                        I_READ:  err_d = !addr_ok;
                        I_WRITE: begin wr_en = addr_ok; err_d = !addr_ok; end
                        I_PARAM: begin wr_en = addr_ok; param_d = addr_ok; err_d = !addr_ok; end
                        I_CLKDV: begin
                            wr_en = addr_ok && (addr_q == ADDR_W'(CLKDIV_ADDR));
                            clk_d = wr_en;
                            err_d = !wr_en;
                        end
                        I_DEBUG: begin
                            wr_en = addr_ok && (addr_q == ADDR_W'(DEBUG_ADDR));
                            dbg_d = wr_en;
                            err_d = !wr_en;
                        end
                        I_BURST: begin
                            wr_en   = addr_ok;
                            err_d   = !addr_ok;
                            done_d  = 1'b0;
                            ptr_d   = {1'b0, addr_q} + 1'b1;
                            state_d = S_BURST;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                S_BURST: begin
                    // Pointer freezes once past the end, so it can never wrap back in range.
                    wr_addr = ptr_q;
                    wr_en   = ptr_ok;
                    err_d   = !ptr_ok;
                    if (ptr_ok) ptr_d = ptr_q + 1'b1;
                end
                default: state_d = S_MSB;
            endcase
        end else if (state_q != S_MSB && gap_q == GW'(TIMEOUT)) begin
            state_d = S_MSB;
            gap_d   = '0;
            if (state_q == S_BURST) done_d = 1'b1;
            else                    abort_d = 1'b1;
        end
    end

    always_ff @(posedge system_clock) begin
        if (!rst_n) begin
            state_q              <= S_MSB;
            msb_q                <= '0;
            addr_q               <= '0;
            instr_q              <= '0;
            ptr_q                <= '0;
            gap_q                <= '0;
            mem                  <= '0;
            tx_byte              <= '0;
            tx_load              <= 1'b0;
            spi_instruction_done <= 1'b0;
            clk_div_load         <= 1'b0;
            debug_config_load    <= 1'b0;
            param_update         <= 1'b0;
            cmd_error            <= 1'b0;
            frame_abort          <= 1'b0;
        end else begin
            state_q              <= state_d;
            msb_q                <= msb_d;
            addr_q               <= addr_d;
            instr_q              <= instr_d;
            ptr_q                <= ptr_d;
            gap_q                <= gap_d;
            tx_byte              <= tx_d;
            tx_load              <= tx_load_d;
            spi_instruction_done <= done_d;
            clk_div_load         <= clk_d;
            debug_config_load    <= dbg_d;
            param_update         <= param_d;
            cmd_error            <= err_d;
            frame_abort          <= abort_d;
            for (int k = 0; k < MEM_BYTES; k++)
                if (wr_en && 32'(wr_addr) == k) mem[k] <= byte_in;
        end
    end

endmodule

// File: tb/tb_spi_cmd_memory_ctrl.sv
// Bench for spi_cmd_memory_ctrl: frame-level reference model checked every cycle, plus
// directed frames with literal expected register values and pulse counts.
module tb_spi_cmd_memory_ctrl;

    localparam int MEM_BYTES = 164;
    localparam int ADDR_W    = 8;
    localparam int CLKDIV    = 6;
    localparam int DEBUG     = 163;
    localparam int TIMEOUT   = 1023;

    // Pulse vector bit positions
    localparam int P_TX = 6, P_DONE = 5, P_CLK = 4, P_DBG = 3, P_PAR = 2, P_ERR = 1, P_ABT = 0;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   byte_valid = 1'b0;
    logic [7:0]             byte_in = 8'h00;
    logic [MEM_BYTES*8-1:0] all_data_out;
    logic [7:0]             tx_byte;
    logic                   tx_load, spi_instruction_done, clk_div_load, debug_config_load;
    logic                   param_update, cmd_error, frame_abort, busy;

    spi_cmd_memory_ctrl #(
        .MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .CLKDIV_ADDR(CLKDIV),
        .DEBUG_ADDR(DEBUG), .TIMEOUT(TIMEOUT)
    ) dut (
        .system_clock(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_in(byte_in),
        .all_data_out(all_data_out), .tx_byte(tx_byte), .tx_load(tx_load),
        .spi_instruction_done(spi_instruction_done), .clk_div_load(clk_div_load),
        .debug_config_load(debug_config_load), .param_update(param_update),
        .cmd_error(cmd_error), .frame_abort(frame_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [7:0] m_mem [MEM_BYTES];
    logic [7:0] m_tx = 8'h00;
    logic [6:0] m_pulse = '0;
    logic [7:0] frame [$];
    bit         m_burst = 1'b0;
    int         m_ptr = 0;
    int         m_idle = 0;

    function automatic int frame_addr();
        return ((int'(frame[0]) << 8) | int'(frame[1])) & ((1 << ADDR_W) - 1);
    endfunction

    task automatic m_write(input int a, input logic [7:0] d);
        if (a < MEM_BYTES) m_mem[a] = d;
    endtask

    task automatic m_exec();
        int a;
        bit ok;
        logic [7:0] d;
        a  = frame_addr();
        ok = a < MEM_BYTES;
        d  = frame[3];
        m_pulse[P_DONE] = 1'b1;
        case (frame[2])
            8'h00: m_pulse[P_ERR] = !ok;
            8'h01: if (ok) m_write(a, d); else m_pulse[P_ERR] = 1'b1;
            8'h07: if (ok) begin m_write(a, d); m_pulse[P_PAR] = 1'b1; end
                   else m_pulse[P_ERR] = 1'b1;
            8'h05: if (ok && a == CLKDIV) begin m_write(a, d); m_pulse[P_CLK] = 1'b1; end
                   else m_pulse[P_ERR] = 1'b1;
            8'h09: if (ok && a == DEBUG) begin m_write(a, d); m_pulse[P_DBG] = 1'b1; end
                   else m_pulse[P_ERR] = 1'b1;
            8'h0B: begin
                m_pulse[P_DONE] = 1'b0;
                m_burst = 1'b1;
                m_ptr   = a + 1;
                if (ok) m_write(a, d); else m_pulse[P_ERR] = 1'b1;
            end
            default: m_pulse[P_ERR] = 1'b1;
        endcase
    endtask

    always @(posedge clk) begin
        m_pulse = '0;
        if (!rst_n) begin
            for (int k = 0; k < MEM_BYTES; k++) m_mem[k] = 8'h00;
            m_tx = 8'h00;
            frame.delete();
            m_burst = 1'b0;
            m_idle  = 0;
        end else if (byte_valid) begin
            m_idle = 0;
            if (m_burst) begin
                if (m_ptr < MEM_BYTES) m_mem[m_ptr] = byte_in;
                else m_pulse[P_ERR] = 1'b1;
                m_ptr++;
            end else begin
                frame.push_back(byte_in);
                if (frame.size() == 3 && byte_in == 8'h00) begin
                    m_pulse[P_TX] = 1'b1;
                    m_tx = (frame_addr() < MEM_BYTES) ? m_mem[frame_addr()] : 8'h00;
                end
                if (frame.size() == 4) begin
                    m_exec();
                    frame.delete();
                end
            end
        end else if (m_burst || frame.size() != 0) begin
            m_idle++;
            if (m_idle > TIMEOUT) begin
                if (m_burst) m_pulse[P_DONE] = 1'b1;
                else         m_pulse[P_ABT]  = 1'b1;
                m_burst = 1'b0;
                frame.delete();
                m_idle = 0;
            end
        end
    end

    // ---------------- per-cycle compare + pulse counters ----------------
    int n_done = 0, n_clk = 0, n_dbg = 0, n_par = 0, n_err = 0, n_abt = 0, n_tx = 0;

    always @(negedge clk) begin
        logic [6:0] act;
        int bad;
        act = {tx_load, spi_instruction_done, clk_div_load, debug_config_load,
               param_update, cmd_error, frame_abort};
        chk("pulses", {25'd0, act}, {25'd0, m_pulse});
        chk("busy", {31'd0, busy}, {31'd0, (m_burst || frame.size() != 0)});
        chk("tx_byte", {24'd0, tx_byte}, {24'd0, m_tx});
        bad = -1;
        for (int k = MEM_BYTES - 1; k >= 0; k--)
            if (all_data_out[8*k +: 8] !== m_mem[k]) bad = k;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL image byte %0d: got %0h expected %0h", bad,
                     all_data_out[8*bad +: 8], m_mem[bad]);
        end
        n_done += int'(spi_instruction_done);
        n_clk  += int'(clk_div_load);
        n_dbg  += int'(debug_config_load);
        n_par  += int'(param_update);
        n_err  += int'(cmd_error);
        n_abt  += int'(frame_abort);
        n_tx   += int'(tx_load);
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 byte_valid = 1'b1;
        byte_in = b;
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, b, c, d);
        send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] img(input int k);
        return all_data_out[8*k +: 8];
    endfunction

    initial begin
        int d0, e0, c0, a0, p0, g0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("reset image", {31'd0, |all_data_out}, 32'd0);

        d0 = n_done;
        send_frame(8'h00, 8'h34, 8'h01, 8'hA5);
        idle(2);
        chk("write 34 image", {24'd0, all_data_out[423:416]}, 32'hA5);
        chk("write 34 done", n_done - d0, 1);

        c0 = n_clk; e0 = n_err;
        send_frame(8'h00, 8'h06, 8'h05, 8'hB6);
        send_frame(8'h00, 8'h07, 8'h05, 8'hB6);
        idle(2);
        chk("clkdiv mem6", {24'd0, img(6)}, 32'hB6);
        chk("clkdiv mem7", {24'd0, img(7)}, 32'h00);
        chk("clkdiv load count", n_clk - c0, 1);
        chk("clkdiv err count", n_err - e0, 1);

        d0 = n_done; g0 = n_dbg;
        send_frame(8'h00, 8'hA3, 8'h09, 8'hD8);
        send_byte(8'h00); send_byte(8'hA3); send_byte(8'h00);
        chk("read tx_load", {31'd0, tx_load}, 32'd1);
        chk("read tx_byte", {24'd0, tx_byte}, 32'hD8);
        send_byte(8'h00);
        idle(2);
        chk("debug load count", n_dbg - g0, 1);
        chk("debug/read done", n_done - d0, 2);

        d0 = n_done; e0 = n_err;
        send_frame(8'h00, 8'hA1, 8'h0B, 8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("burst busy", {31'd0, busy}, 32'd1);
        idle(TIMEOUT + 10);
        chk("burst A1", {24'd0, img(8'hA1)}, 32'h11);
        chk("burst A2", {24'd0, img(8'hA2)}, 32'h22);
        chk("burst A3", {24'd0, img(8'hA3)}, 32'h33);
        chk("burst err", n_err - e0, 1);
        chk("burst done", n_done - d0, 1);
        chk("burst idle", {31'd0, busy}, 32'd0);

        a0 = n_abt;
        send_byte(8'h00); send_byte(8'h05);
        idle(TIMEOUT + 10);
        send_frame(8'h00, 8'h05, 8'h01, 8'h19);
        idle(2);
        chk("abort count", n_abt - a0, 1);
        chk("after abort mem5", {24'd0, img(5)}, 32'h19);

        a0 = n_abt;
        send_byte(8'h00); send_byte(8'h10);
        idle(TIMEOUT - 1);
        send_byte(8'h01); send_byte(8'h5A);
        idle(2);
        chk("edge gap no abort", n_abt - a0, 0);
        chk("edge gap mem10", {24'd0, img(8'h10)}, 32'h5A);

        p0 = n_par; e0 = n_err;
        send_frame(8'h01, 8'h20, 8'h01, 8'h77);
        send_frame(8'h00, 8'h30, 8'h07, 8'hC3);
        send_frame(8'h00, 8'h40, 8'h03, 8'h99);
        idle(2);
        chk("addr trunc mem20", {24'd0, img(8'h20)}, 32'h77);
        chk("param mem30", {24'd0, img(8'h30)}, 32'hC3);
        chk("param count", n_par - p0, 1);
        chk("bad instr mem40", {24'd0, img(8'h40)}, 32'h00);
        chk("bad instr err", n_err - e0, 1);

        e0 = n_err;
        send_byte(8'h00); send_byte(8'hC8); send_byte(8'h00);
        chk("oor read tx_load", {31'd0, tx_load}, 32'd1);
        chk("oor read tx_byte", {24'd0, tx_byte}, 32'h00);
        send_byte(8'h55);
        send_frame(8'h00, 8'hC8, 8'h01, 8'h12);
        idle(2);
        chk("oor err count", n_err - e0, 2);

        d0 = n_done; e0 = n_err; a0 = n_abt;
        send_byte(8'h00); send_byte(8'h05);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(TIMEOUT + 20);
        chk("reset mid abort", n_abt - a0, 0);
        chk("reset mid done", n_done - d0, 0);
        chk("reset mid err", n_err - e0, 0);
        chk("reset mid image", {31'd0, |all_data_out}, 32'd0);
        chk("reset mid busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_cmd_memory_ctrl.md
SPI_CMD_MEMORY_CTRL -- requirements
Module: spi_cmd_memory_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 164; number of byte-wide configuration registers.
REQ-002 SHALL have parameter ADDR_W, default 8, range 8..16; number of address bits used from the {msb,lsb} frame address.
REQ-003 SHALL have parameter CLKDIV_ADDR, default 6; clock-divider register address.
REQ-004 SHALL have parameter DEBUG_ADDR, default 163; debug-config register address.
REQ-005 SHALL have parameter TIMEOUT, default 1023; maximum idle system_clock cycles allowed between bytes of one frame.
REQ-006 system_clock  in  1  single clock; all logic rising-edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 byte_valid  in  1  one-cycle strobe; a received SPI byte is present on byte_in.
REQ-009 byte_in  in  8  received byte.
REQ-010 all_data_out  out  MEM_BYTES*8  flat register image; byte k at bits [8k+7:8k].
REQ-011 tx_byte  out  8  read-back byte for the SPI shifter.
REQ-012 tx_load, spi_instruction_done, clk_div_load, debug_config_load, param_update, cmd_error, frame_abort  out  1 each  one-cycle pulses.
REQ-013 busy  out  1  high whenever the FSM is not in S_MSB.

Function
REQ-014 SHALL assemble each frame from 4 bytes in this order: addr_msb, addr_lsb, instr, data; addr = {msb,lsb}[ADDR_W-1:0].
REQ-015 FSM states SHALL be S_MSB -> S_LSB -> S_INSTR -> S_DATA -> S_MSB, each advancing on byte_valid; S_DATA goes to S_BURST for instr 0x0B.
REQ-016 Instr 0x00 (read), on the instr byte: tx_byte <= mem[addr] and tx_load pulse, in the cycle after byte_valid; the data byte is consumed and no write occurs.
REQ-017 Instr 0x01: mem[addr] <= data.
REQ-018 Instr 0x07: mem[addr] <= data and param_update pulse.
REQ-019 Instr 0x05: write and clk_div_load pulse only if addr==CLKDIV_ADDR; otherwise no write and cmd_error pulse.
REQ-020 Instr 0x09: write and debug_config_load pulse only if addr==DEBUG_ADDR; otherwise no write and cmd_error pulse.
REQ-021 Instr 0x0B (burst): data byte writes mem[addr]; each further byte_valid writes mem[addr+n] for n=1,2,...
REQ-022 Burst SHALL end by timeout only; bytes whose address is >= MEM_BYTES SHALL be discarded and each SHALL raise cmd_error; the address SHALL NOT wrap.
REQ-023 Any other instr code: data byte consumed, no write, cmd_error pulse.
REQ-024 addr >= MEM_BYTES: no write, cmd_error pulse; a read returns tx_byte=0x00 with tx_load.
REQ-025 Write latency: mem and all_data_out update on the edge following the data byte's byte_valid cycle; load/update pulses occur on that same edge.
REQ-026 spi_instruction_done SHALL pulse once per completed frame, on the data byte, including error frames; in burst mode it pulses once, when the burst ends.
REQ-027 Gap counter SHALL reset on every byte_valid and count in every state except S_MSB.
REQ-028 When the gap counter reaches TIMEOUT in S_LSB, S_INSTR or S_DATA: return to S_MSB, no write, frame_abort pulse.
REQ-029 When the gap counter reaches TIMEOUT in S_BURST: return to S_MSB, spi_instruction_done pulse, no frame_abort.
REQ-030 byte_valid in the same cycle as timeout expiry: byte_valid wins; the byte is processed in the current state and the counter is cleared.
REQ-031 Pulse outputs SHALL be low in every cycle not specified above.

Reset
REQ-032 rst_n=0 at a clock edge SHALL set: FSM to S_MSB, all mem bytes to 0x00, tx_byte 0x00, all pulse outputs 0, busy 0, gap counter 0.
REQ-033 Reset mid-frame or mid-burst SHALL discard the partial frame and suppress all pulses, including frame_abort.

Verification
REQ-034 Bytes 00,34,01,A5 -> mem[0x34]=A5, all_data_out[423:416]=A5, one spi_instruction_done pulse.
REQ-035 Bytes 00,06,05,B6 -> mem[6]=B6 and clk_div_load; bytes 00,07,05,B6 -> mem[7] unchanged and cmd_error.
REQ-036 Write 00,A3,09,D8, then read 00,A3,00,00 -> tx_byte=D8 with tx_load after the 3rd byte; 2 done pulses total.
REQ-037 Burst 00,A1,0B,11 then 22,33,44, then a gap > TIMEOUT -> mem[A1]=11, mem[A2]=22, mem[A3]=33; 44 discarded with cmd_error; one done pulse.
REQ-038 Bytes 00,05, then a gap > TIMEOUT, then 00,05,01,19 -> frame_abort once, then mem[5]=19; with rst_n=0 after the 2nd byte instead -> no pulses, mem all zero.
